// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: VGA timing monitor (coordinates, line/frame measurement, lock).
// Optional VGA_RX_CRC_EN adds a CRC-16-CCITT over each frame's active pixels.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_ce,
  input  logic        hs_n,
  input  logic        vs_n,
  input  logic        blank_n,
  input  logic [23:0] rgb,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        err,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    TRACK,
    LOCK
  } state_t;

  state_t      state;
  logic        hs_p;
  logic        vs_p;
  logic        bl_p;
  logic [10:0] x;
  logic [10:0] lcnt;
  logic [9:0]  y;
  logic [9:0]  fcnt;
  logic [7:0]  good;
  logic        hs_f;
  logic        vs_f;
  logic        bl_f;
  logic        trk;
  logic        run_bad;
  logic        line_bad;
  logic        frm_bad;
  logic        bad;

  assign hs_f = pix_ce & hs_p & ~hs_n;
  assign vs_f = pix_ce & vs_p & ~vs_n;
  assign bl_f = pix_ce & bl_p & ~blank_n;
  assign trk  = (state == TRACK) | (state == LOCK);

  // An active run must be exactly H_ACTIVE: too long trips on the
  // extra pixel, too short trips when blank_n falls.
  assign run_bad = pix_ce & (blank_n ? (x >= 11'(H_ACTIVE))
                                     : (bl_p & (x != 11'(H_ACTIVE))));
  assign line_bad = hs_f & (lcnt != 11'(H_TOTAL));
  assign frm_bad  = vs_f & ((fcnt != 10'(V_TOTAL)) |
                            (y != 10'(V_ACTIVE)));
  assign bad = trk & (run_bad | line_bad | frm_bad);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_p        <= 1'b1;
      vs_p        <= 1'b1;
      bl_p        <= 1'b1;
      x           <= '0;
      y           <= '0;
      lcnt        <= '0;
      fcnt        <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      frame_start <= vs_f;
      rx_valid    <= pix_ce & blank_n & trk;
      if (pix_ce) begin
        hs_p <= hs_n;
        vs_p <= vs_n;
        bl_p <= blank_n;
        if (blank_n) begin
          rx_x <= x[9:0];
          rx_y <= y;
          if (x != 11'h7FF) x <= x + 11'd1;
        end else begin
          x <= '0;
        end
        if (vs_f) y <= '0;
        else if (bl_f && y != 10'h3FF) y <= y + 10'd1;
        if (hs_f) begin
          line_len <= lcnt;
          lcnt     <= 11'd1;
        end else if (lcnt != 11'h7FF) begin
          lcnt <= lcnt + 11'd1;
        end
        // A coincident hs fall opens the new frame as its first line.
        if (vs_f) begin
          frame_lines <= fcnt;
          fcnt        <= {9'd0, hs_f};
        end else if (hs_f && fcnt != 10'h3FF) begin
          fcnt <= fcnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= SEARCH;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else if (bad) begin
      state  <= SEARCH;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b1;
    end else begin
      unique case (state)
        SEARCH: if (vs_f) state <= ALIGN;
        ALIGN:  if (hs_f) state <= TRACK;
        TRACK: begin
          if (vs_f) begin
            good <= good + 8'd1;
            if (good + 8'd1 >= 8'(LOCK_FRAMES)) begin
              state  <= LOCK;
              locked <= 1'b1;
              err    <= 1'b0;
            end
          end
        end
        LOCK:    if (vs_f) err <= 1'b0;
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_px(
    input logic [15:0] c,
    input logic [23:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_f) begin
      frame_crc <= crc;
      crc       <= 16'hFFFF;
    end else if (pix_ce & blank_n) begin
      crc <= crc_px(crc, rgb);
    end
  end
`else
  logic unused_rgb;

  assign unused_rgb = ^rgb;
  assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: scaled-timing bench for vga_sync_receiver.
// Table vectors, hand sequences and a tick-level reference model.
`timescale 1ns/1ps
module tb_vga_sync_receiver;
  localparam int HT  = 40;
  localparam int HA  = 32;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int LF  = 2;
  localparam int HS0 = 34;
  localparam int HS1 = 37;
  localparam int VSL = 10;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_ce;
  logic        hs_n;
  logic        vs_n;
  logic        blank_n;
  logic [23:0] rgb;
  logic [9:0]  rx_x;
  logic [9:0]  rx_y;
  logic        rx_valid;
  logic        frame_start;
  logic        locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        err;
  logic [15:0] frame_crc;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT),
    .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce),
    .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n), .rgb(rgb),
    .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid),
    .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines),
    .err(err), .frame_crc(frame_crc)
  );

  always #10 Clk = ~Clk;

  int n_chk;
  int n_fail;
  int hand;
  int rgb_mode;

  bit p_hs, p_vs, p_bl;
  int t, last_hs_t, frame_hs, m_x, m_y, phase, good;
  bit e_valid, e_fs, e_locked, e_err;
  int e_x, e_y, e_len, e_lines;
  logic [15:0] m_crc, e_crc;

  typedef struct {
    bit hs; bit vs; bit bl;
    bit fs; bit vl; int x; bit er;
  } vec_t;
  vec_t tv[9];

  function automatic logic [15:0] ref_crc(input logic [15:0] c,
                                          input logic [23:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 24; i++) begin
      fb = r[15] ^ d[23-i];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("rx_valid", rx_valid, e_valid);
    chk("frame_start", frame_start, e_fs);
    chk("locked", locked, e_locked);
    chk("err", err, e_err);
    chk("rx_x", rx_x, e_x);
    chk("rx_y", rx_y, e_y);
    chk("line_len", line_len, e_len);
    chk("frame_lines", frame_lines, e_lines);
    chk("frame_crc", frame_crc, e_crc);
  endtask

  task automatic model_reset();
    p_hs = 1; p_vs = 1; p_bl = 1;
    last_hs_t = t; frame_hs = 0; m_x = 0; m_y = 0;
    phase = 0; good = 0;
    e_valid = 0; e_fs = 0; e_locked = 0; e_err = 0;
    e_x = 0; e_y = 0; e_len = 0; e_lines = 0;
    m_crc = 16'hFFFF; e_crc = 16'h0;
  endtask

  // phase: 0 searching for vsync, 1 waiting for first hsync, 2 tracking
  task automatic model_tick(input bit hs, input bit vs, input bit bl,
                            input logic [23:0] d);
    bit hf, vf, bf, trk, bad, ok;
    hf = p_hs && !hs;
    vf = p_vs && !vs;
    bf = p_bl && !bl;
    trk = (phase == 2);
    bad = 0;
    ok = 1;
    e_fs = vf;
    e_valid = bl && trk;
    if (bl) begin
      if (trk && m_x >= HA) bad = 1;
      e_x = m_x % 1024;
      e_y = m_y;
      if (m_x < 2047) m_x++;
    end else begin
      if (bf && trk && m_x != HA) bad = 1;
      m_x = 0;
    end
    if (hf) begin
      e_len = (t - last_hs_t > 2047) ? 2047 : t - last_hs_t;
      last_hs_t = t;
      if (trk && e_len != HT) bad = 1;
    end
    if (vf) begin
      e_lines = frame_hs;
      ok = (frame_hs == VT) && (m_y == VA);
      frame_hs = hf ? 1 : 0;
      m_y = 0;
`ifdef VGA_RX_CRC_EN
      e_crc = m_crc;
`endif
      m_crc = 16'hFFFF;
    end else begin
      if (hf && frame_hs < 1023) frame_hs++;
      if (bf && m_y < 1023) m_y++;
      if (bl) m_crc = ref_crc(m_crc, d);
    end
    if (trk && (bad || !ok)) begin
      phase = 0; good = 0; e_locked = 0; e_err = 1;
    end else if (phase == 0) begin
      if (vf) phase = 1;
    end else if (phase == 1) begin
      if (hf) phase = 2;
    end else if (vf) begin
      good++;
      if (good >= LF) begin
        e_locked = 1;
        e_err = 0;
      end
    end
    t++;
    p_hs = hs; p_vs = vs; p_bl = bl;
  endtask

  task automatic tick(input bit hs, input bit vs, input bit bl,
                      input logic [23:0] d);
    hs_n = hs; vs_n = vs; blank_n = bl; rgb = d; pix_ce = 1'b1;
    @(posedge Clk); #1;
    model_tick(hs, vs, bl, d);
    chk_all();
    pix_ce = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      e_valid = 0;
      e_fs = 0;
      chk_all();
    end
  endtask

  task automatic do_reset();
    #3 Reset_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    chk("async_rst_locked", locked, 0);
    chk("async_rst_len", line_len, 0);
    #2 Reset_n = 1'b1;
  endtask

  task automatic frame(input int vt, input int sl, input int slen,
                       input int al, input int alen,
                       input int rv, input int rc);
    for (int v = 0; v < vt; v++) begin
      int hl, ha;
      hl = (v == sl) ? slen : HT;
      ha = (v >= VA) ? 0 : ((v == al) ? alen : HA);
      for (int c = 0; c < hl; c++) begin
        logic [23:0] d;
        int g;
        if (rgb_mode == 0) d = 24'($urandom);
        else if (rgb_mode == 2 && v == 0 && c == 0) d = 24'hFFFFFF;
        else d = 24'h0;
        tick(!(c >= HS0 && c <= HS1), v != VSL, c < ha, d);
        if (hand == 3 && v == VA-1 && c == HA-1) begin
          chk("corner_x", rx_x, HA-1);
          chk("corner_y", rx_y, VA-1);
          chk("corner_valid", rx_valid, 1);
        end
        if (hand == 3 && v == VA-1 && c == HA)
          chk("after_corner_valid", rx_valid, 0);
        if (hand == 2 && v == sl+1 && c == HS0) begin
          chk("short_line_err", err, 1);
          chk("short_line_locked", locked, 0);
        end
        if (hand == 5 && v == 2 && c == HS0)
          chk("stall_line_len", line_len, HT);
        g = (hand == 5 && v == 2 && c == 15) ? 100
                                             : int'($urandom_range(1, 2));
        idle(g);
        if (v == rv && c == rc) do_reset();
      end
    end
  endtask

  initial begin
    logic [15:0] crc_blk, crc_wht;
    n_chk = 0; n_fail = 0; hand = 0; rgb_mode = 0; t = 0;
    pix_ce = 0; hs_n = 1; vs_n = 1; blank_n = 0; rgb = '0;
    Reset_n = 1'b0;
    model_reset();

    tv[0] = '{1, 1, 0, 0, 0, 0, 0};
    tv[1] = '{1, 0, 0, 1, 0, 0, 0};
    tv[2] = '{1, 0, 1, 0, 0, 0, 0};
    tv[3] = '{0, 0, 1, 0, 0, 1, 0};
    tv[4] = '{0, 0, 1, 0, 1, 2, 0};
    tv[5] = '{1, 0, 1, 0, 1, 3, 0};
    tv[6] = '{1, 1, 0, 0, 0, 3, 1};
    tv[7] = '{1, 0, 0, 1, 0, 3, 1};
    tv[8] = '{1, 0, 1, 0, 0, 0, 1};

    crc_blk = 16'h0;
    crc_wht = 16'h0;
`ifdef VGA_RX_CRC_EN
    crc_blk = 16'hFFFF;
    crc_wht = 16'hFFFF;
    for (int i = 0; i < HA*VA; i++) begin
      crc_blk = ref_crc(crc_blk, 24'h0);
      crc_wht = ref_crc(crc_wht, (i == 0) ? 24'hFFFFFF : 24'h0);
    end
`endif

    repeat (2) @(posedge Clk);
    #1;
    chk_all();
    Reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick(tv[i].hs, tv[i].vs, tv[i].bl, 24'h0);
      chk("tv_frame_start", frame_start, tv[i].fs);
      chk("tv_rx_valid", rx_valid, tv[i].vl);
      chk("tv_rx_x", rx_x, tv[i].x);
      chk("tv_err", err, tv[i].er);
      idle(1);
    end
    do_reset();

    repeat (3) frame(VT, -1, 0, -1, 0, -1, -1);
    chk("t1_locked", locked, 1);
    chk("t1_line_len", line_len, HT);
    chk("t1_frame_lines", frame_lines, VT);
    chk("t1_err", err, 0);

    hand = 3;
    frame(VT, -1, 0, -1, 0, -1, -1);
    hand = 5;
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("stall_locked", locked, 1);

    hand = 2;
    frame(VT, 3, HT-1, -1, 0, -1, -1);
    hand = 0;
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("relock_wait", locked, 0);
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("relock_locked", locked, 1);
    chk("relock_err", err, 0);

    frame(VT, -1, 0, -1, 0, 5, 10);
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("post_rst_nolock", locked, 0);
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("post_rst_lock", locked, 1);

    for (int f = 0; f < 8; f++) begin
      int k;
      k = int'($urandom_range(0, 4));
      if (k == 1)
        frame(VT, int'($urandom_range(0, VT-1)),
              ($urandom_range(0, 1) != 0) ? HT+1 : HT-1, -1, 0, -1, -1);
      else if (k == 2)
        frame(VT, -1, 0, int'($urandom_range(0, VA-1)),
              ($urandom_range(0, 1) != 0) ? HA+1 : HA-1, -1, -1);
      else if (k == 3)
        frame(VT+1, -1, 0, -1, 0, -1, -1);
      else if (k == 4)
        frame(VT-1, -1, 0, -1, 0, -1, -1);
      else
        frame(VT, -1, 0, -1, 0, -1, -1);
    end

    rgb_mode = 1;
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("crc_black", frame_crc, crc_blk);
    rgb_mode = 2;
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("crc_white_px", frame_crc, crc_wht);
    rgb_mode = 1;
    frame(VT, -1, 0, -1, 0, -1, -1);
    chk("crc_black_again", frame_crc, crc_blk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
